// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared cpu constants and fetch state encoding
//
// Purpose : common word width, NOP encoding and fetch FSM state type.
// Contents: WORD_W, NOP, state_t {FETCH, ISSUE}.
package fetch_pc_unit_pkg;

    localparam int WORD_W = 24;
    localparam logic [WORD_W-1:0] NOP = 24'h000000;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch stage bus: imem handshake, decode handoff, redirect
//
// Purpose : bundles every fetch-stage signal except clock and reset.
// Signals : Stall, BranchTaken, BranchTarget  (decode/execute -> fetch)
//           ImemReq, ImemAddr                  (fetch -> imem)
//           ImemAck, ImemData                  (imem -> fetch)
//           InstrValid, Instr, InstrPC         (fetch -> decode)
// Modports: master = fetch unit, slave = its environment.
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic              Stall;
    logic              BranchTaken;
    logic [WORD_W-1:0] BranchTarget;
    logic              ImemReq;
    logic [WORD_W-1:0] ImemAddr;
    logic              ImemAck;
    logic [WORD_W-1:0] ImemData;
    logic              InstrValid;
    logic [WORD_W-1:0] Instr;
    logic [WORD_W-1:0] InstrPC;

    modport master (
        input  Stall, BranchTaken, BranchTarget, ImemAck, ImemData,
        output ImemReq, ImemAddr, InstrValid, Instr, InstrPC
    );

    modport slave (
        output Stall, BranchTaken, BranchTarget, ImemAck, ImemData,
        input  ImemReq, ImemAddr, InstrValid, Instr, InstrPC
    );

endinterface

// File: rtl/fetch_pc_unit_mux2ne1_24bit.sv
// rtl/fetch_pc_unit_mux2ne1_24bit.sv - 24-bit 2:1 mux built from Mux2ne1 cells
//
// Purpose : word-wide 2:1 select; all bit cells share one select.
// Ports   : a (selected when s=0), b (selected when s=1), s, y.
module Mux2ne1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module mux2ne1_24bit
    import fetch_pc_unit_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              s,
    output logic [WORD_W-1:0] y
);
    for (genvar i = 0; i < WORD_W; i++) begin : g_bit
        Mux2ne1 u_cell (
            .a (a[i]),
            .b (b[i]),
            .s (s),
            .y (y[i])
        );
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - instruction fetch stage: PC, imem req/ack, redirect handling
//
// Purpose : holds the PC, fetches one instruction at a time from imem and
//           presents it to decode; accepts branch redirects at any time.
// Ports   : Clock  - rising-edge clock
//           Reset  - synchronous active-high reset
//           bus    - fetch_pc_unit_if.master (imem, decode and redirect signals)
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 24'h000000,
    parameter logic [WORD_W-1:0] PC_STEP  = 24'd1
) (
    input  logic           Clock,
    input  logic           Reset,
    fetch_pc_unit_if.master bus
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              redirect_pend_q, redirect_pend_d;
    logic [WORD_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              instr_valid_q, instr_valid_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] instr_pc_q, instr_pc_d;

    logic [WORD_W-1:0] seq_pc;
    logic [WORD_W-1:0] redir_pc;
    logic              redirect;
    logic [WORD_W-1:0] next_pc;

    // Wraps modulo 2^24 by width truncation.
    assign seq_pc   = pc_q + PC_STEP;
    // A live branch overrides a remembered one (latest target wins).
    assign redir_pc = bus.BranchTaken ? bus.BranchTarget : pend_tgt_q;
    // redirect_pend is only ever set in FETCH, so in ISSUE this reduces to BranchTaken.
    assign redirect = bus.BranchTaken | redirect_pend_q;

    mux2ne1_24bit u_next_pc_mux (
        .a (seq_pc),
        .b (redir_pc),
        .s (redirect),
        .y (next_pc)
    );

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redirect_pend_d = redirect_pend_q;
        pend_tgt_d      = pend_tgt_q;
        instr_valid_d   = instr_valid_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        case (state_q)
            FETCH: begin
                if (bus.ImemAck) begin
                    // On a redirect the returned word is for a dead path: drop it
                    // and re-request from the target.
                    pc_d            = next_pc;
                    redirect_pend_d = 1'b0;
                    if (!redirect) begin
                        instr_d       = bus.ImemData;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = ISSUE;
                    end
                end else if (bus.BranchTaken) begin
                    // PC must stay put while the request is outstanding.
                    redirect_pend_d = 1'b1;
                    pend_tgt_d      = bus.BranchTarget;
                end
            end
            ISSUE: begin
                if (bus.BranchTaken) begin
                    instr_valid_d = 1'b0;
                    pc_d          = next_pc;
                    state_d       = FETCH;
                end else if (!bus.Stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q         <= FETCH;
            pc_q            <= RESET_PC;
            redirect_pend_q <= 1'b0;
            pend_tgt_q      <= NOP;
            instr_valid_q   <= 1'b0;
            instr_q         <= NOP;
            instr_pc_q      <= NOP;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            redirect_pend_q <= redirect_pend_d;
            pend_tgt_q      <= pend_tgt_d;
            instr_valid_q   <= instr_valid_d;
            instr_q         <= instr_d;
            instr_pc_q      <= instr_pc_d;
        end
    end

    assign bus.ImemReq    = (state_q == FETCH) && !Reset;
    assign bus.ImemAddr   = pc_q;
    assign bus.InstrValid = instr_valid_q;
    assign bus.Instr      = instr_q;
    assign bus.InstrPC    = instr_pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    localparam logic [23:0] RST_PC = 24'h000100;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(RST_PC), .PC_STEP(24'd1)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: "holding an instruction" or "fetching", plus at most
    // one remembered redirect target.
    bit          m_known = 0;
    bit          m_hold  = 0;
    logic [23:0] m_pc    = '0;
    logic [23:0] m_instr = '0;
    logic [23:0] m_ipc   = '0;
    logic [23:0] m_redir[$];

    logic        s_req, s_valid;
    logic [23:0] s_addr, s_instr, s_ipc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic bt,
                        input logic [23:0] tgt, input logic ack, input logic [23:0] data);
        Reset            = rst;
        bus.Stall        = st;
        bus.BranchTaken  = bt;
        bus.BranchTarget = tgt;
        bus.ImemAck      = ack;
        bus.ImemData     = data;
        #1;
        s_req   = bus.ImemReq;
        s_addr  = bus.ImemAddr;
        s_valid = bus.InstrValid;
        s_instr = bus.Instr;
        s_ipc   = bus.InstrPC;
        check("imem_req", {31'b0, s_req}, {31'b0, (!rst && !m_hold)});
        if (m_known) begin
            check("imem_addr",   {8'b0, s_addr},  {8'b0, m_pc});
            check("instr_valid", {31'b0, s_valid}, {31'b0, m_hold});
            check("instr",       {8'b0, s_instr}, {8'b0, m_instr});
            check("instr_pc",    {8'b0, s_ipc},   {8'b0, m_ipc});
        end
        @(posedge Clock);
        if (rst) begin
            m_known = 1;
            m_hold  = 0;
            m_pc    = RST_PC;
            m_instr = '0;
            m_ipc   = '0;
            m_redir.delete();
        end else if (!m_hold) begin
            if (ack) begin
                if (bt || m_redir.size() != 0) begin
                    m_pc = bt ? tgt : m_redir[0];
                    m_redir.delete();
                end else begin
                    m_instr = data;
                    m_ipc   = m_pc;
                    m_hold  = 1;
                    m_pc    = m_pc + 24'd1;
                end
            end else if (bt) begin
                m_redir.delete();
                m_redir.push_back(tgt);
            end
        end else begin
            if (bt) begin
                m_hold = 0;
                m_pc   = tgt;
            end else if (!st) begin
                m_hold = 0;
            end
        end
        @(negedge Clock);
    endtask

    initial begin
        int          wait_cnt;
        int          lat;
        logic [31:0] r;
        logic        rr, rs, rb, ra;
        logic [23:0] rt, rd;

        @(negedge Clock);

        // 1: reset, then three fetches with ack one cycle after request
        step(1, 0, 0, 0, 0, 0);
        check("t1_req_in_reset", {31'b0, s_req}, 32'd0);
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0);
            check("t1_addr", {8'b0, s_addr}, 32'h100 + k);
            check("t1_valid_req_cycle", {31'b0, s_valid}, 32'd0);
            step(0, 0, 0, 0, 1, 24'h111000 + k[23:0]);
            step(0, 0, 0, 0, 0, 0);
            check("t1_valid", {31'b0, s_valid}, 32'd1);
            check("t1_instr_pc", {8'b0, s_ipc}, 32'h100 + k);
        end

        // 2: stall 4 cycles while holding ABCDEF
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 24'hABCDEF);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, 0, 0);
            check("t2_instr_held", {8'b0, s_instr}, 32'hABCDEF);
            check("t2_valid_held", {31'b0, s_valid}, 32'd1);
            check("t2_req_low", {31'b0, s_req}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t2_refetch", {31'b0, s_req}, 32'd1);

        // 3: branch while request at 0x200 waits 3 cycles for ack
        step(0, 0, 0, 0, 1, 24'h222222);
        step(0, 0, 1, 24'h000200, 0, 0);
        step(0, 0, 1, 24'h000800, 0, 0);
        check("t3_addr_hold0", {8'b0, s_addr}, 32'h200);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t3_addr_hold2", {8'b0, s_addr}, 32'h200);
        step(0, 0, 0, 0, 1, 24'h123456);
        step(0, 0, 0, 0, 0, 0);
        check("t3_dropped", {31'b0, s_valid}, 32'd0);
        check("t3_new_addr", {8'b0, s_addr}, 32'h800);
        step(0, 0, 0, 0, 1, 24'h654321);

        // 4: branch in ISSUE while stalled
        step(0, 1, 1, 24'h0000F0, 0, 0);
        check("t3_instr_pc", {8'b0, s_ipc}, 32'h800);
        step(0, 0, 0, 0, 1, 24'h0F0F0F);
        check("t4_valid_drop", {31'b0, s_valid}, 32'd0);
        check("t4_addr", {8'b0, s_addr}, 32'h0F0);

        // 5: fetch at 0xFFFFFF wraps to 0
        step(0, 0, 1, 24'hFFFFFF, 0, 0);
        step(0, 0, 0, 0, 1, 24'h00FFFF);
        step(0, 0, 0, 0, 0, 0);
        check("t5_instr_pc", {8'b0, s_ipc}, 32'hFFFFFF);
        step(0, 0, 0, 0, 1, 24'h000777);
        check("t5_wrap_addr", {8'b0, s_addr}, 32'h000000);

        // 6: reset during outstanding request at 0x300, stale ack in reset cycle
        step(0, 0, 1, 24'h000300, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t6_addr", {8'b0, s_addr}, 32'h300);
        step(1, 0, 0, 0, 1, 24'hDEAD00);
        check("t6_req_in_reset", {31'b0, s_req}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check("t6_valid", {31'b0, s_valid}, 32'd0);
        check("t6_addr_rst", {8'b0, s_addr}, {8'b0, RST_PC});

        // Randomized traffic with a variable-latency memory responder
        wait_cnt = 0;
        lat      = 1;
        for (int c = 0; c < 4000; c++) begin
            rr = ($urandom_range(0, 149) == 0);
            rs = ($urandom_range(0, 9) < 3);
            rb = ($urandom_range(0, 9) == 0);
            r  = $urandom;
            rt = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : r[23:0];
            r  = $urandom;
            rd = r[23:0];
            if (!rr && !m_hold) begin
                if (wait_cnt >= lat) begin
                    ra       = 1;
                    wait_cnt = 0;
                    lat      = $urandom_range(0, 3);
                end else begin
                    ra = 0;
                    wait_cnt++;
                end
            end else begin
                ra = ($urandom_range(0, 31) == 0);
                if (rr) wait_cnt = 0;
            end
            step(rr, rs, rb, rt, ra, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
